// File: rtl/cdc_sync_filt.sv
// cdc_sync_filt: multi-channel synchronizer for asynchronous pins.
// Each channel passes through a STAGE-deep flop chain and then a
// stability filter. The filtered level only changes once the synchronized
// value has disagreed with it for more than filt_thr_i consecutive edges.
// Registered rise/fall pulses mark the cycle the filtered level changes.
// All outputs come straight from flops; no input reaches an output
// combinationally.
module cdc_sync_filt #(
    parameter int unsigned         STAGE    = 2,
    parameter int unsigned         CHANNELS = 1,
    parameter int unsigned         FILT_W   = 4,
    parameter logic [CHANNELS-1:0] RST_VAL  = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] dat_i,
    input  logic [FILT_W-1:0]   filt_thr_i,
    output logic [CHANNELS-1:0] dat_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o
);

    // A single flop cannot resolve metastability, so a chain shorter than
    // two is refused at elaboration.
    generate
        if (STAGE < 32'd2) begin : g_bad_stage
            $error("cdc_sync_filt: STAGE must be >= 2");
        end
    endgenerate

    logic [STAGE-1:0][CHANNELS-1:0]  sync_q;
    logic [STAGE-1:0][CHANNELS-1:0]  sync_d;
    logic [CHANNELS-1:0][FILT_W-1:0] cnt_q;
    logic [CHANNELS-1:0][FILT_W-1:0] cnt_d;
    logic [CHANNELS-1:0]             dat_q;
    logic [CHANNELS-1:0]             dat_d;
    logic [CHANNELS-1:0]             rise_q;
    logic [CHANNELS-1:0]             rise_d;
    logic [CHANNELS-1:0]             fall_q;
    logic [CHANNELS-1:0]             fall_d;
    logic [CHANNELS-1:0]             sync_lvl_s;

    // Synchronized level as seen by the filter: the last flop of the chain.
    assign sync_lvl_s = sync_q[STAGE-1];

    // Sync chain next state: pure flop-to-flop shift, no logic in between.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = dat_i;
        for (int k = 1; k < int'(STAGE); k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Stability filter: count disagreeing edges, commit the new level once
    // the count has reached the threshold and raise the matching pulse.
    always_comb begin
        cnt_d  = cnt_q;
        dat_d  = dat_q;
        rise_d = {CHANNELS{1'b0}};
        fall_d = {CHANNELS{1'b0}};
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (sync_lvl_s[c] == dat_q[c]) begin
                // Agreement (or a glitch that ended) discards any partial count.
                cnt_d[c] = {FILT_W{1'b0}};
            end else if (cnt_q[c] >= filt_thr_i) begin
                // Using >= lets a lowered threshold fire on the next edge.
                dat_d[c]  = sync_lvl_s[c];
                cnt_d[c]  = {FILT_W{1'b0}};
                rise_d[c] = sync_lvl_s[c];
                fall_d[c] = ~sync_lvl_s[c];
            end else begin
                // cnt_q < threshold here, so the increment can never wrap.
                cnt_d[c] = cnt_q[c] + FILT_W'(1'b1);
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGE{RST_VAL}};
            dat_q  <= RST_VAL;
            cnt_q  <= {(CHANNELS*FILT_W){1'b0}};
            rise_q <= {CHANNELS{1'b0}};
            fall_q <= {CHANNELS{1'b0}};
        end else begin
            sync_q <= sync_d;
            dat_q  <= dat_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dat_o  = dat_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule
